// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, opcode type and arbiter FSM states shared by
// the ALU datapath, the arbiter and the bus interface.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 4'd0;
  localparam alu_op_t OP_SUB  = 4'd1;
  localparam alu_op_t OP_SLT  = 4'd2;
  localparam alu_op_t OP_SLTU = 4'd3;
  localparam alu_op_t OP_XOR  = 4'd4;
  localparam alu_op_t OP_OR   = 4'd5;
  localparam alu_op_t OP_AND  = 4'd6;
  localparam alu_op_t OP_SLL  = 4'd7;
  localparam alu_op_t OP_SRL  = 4'd8;
  localparam alu_op_t OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Opcodes 10..15 are undefined and complete with an error flag.
  function automatic logic is_legal_op(input alu_op_t op);
    return op <= OP_SRA;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between two requesters and the
// shared ALU arbiter.
//   req0/req1 : valid/ready handshake carrying op_a, op_b and alu_op
//   rsp0/rsp1 : valid/ready handshake carrying data and err
//   o_busy    : arbiter is not idle
//   o_op_count: responses consumed so far (wrapping)
// Modports: slave = arbiter side, master = requester side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             i_req0_valid;
  logic             o_req0_ready;
  logic [31:0]      i_req0_op_a;
  logic [31:0]      i_req0_op_b;
  alu_op_t          i_req0_alu_op;

  logic             i_req1_valid;
  logic             o_req1_ready;
  logic [31:0]      i_req1_op_a;
  logic [31:0]      i_req1_op_b;
  alu_op_t          i_req1_alu_op;

  logic             o_rsp0_valid;
  logic             i_rsp0_ready;
  logic [31:0]      o_rsp0_data;
  logic             o_rsp0_err;

  logic             o_rsp1_valid;
  logic             i_rsp1_ready;
  logic [31:0]      o_rsp1_data;
  logic             o_rsp1_err;

  logic             o_busy;
  logic [CNT_W-1:0] o_op_count;

  modport slave (
    input  i_req0_valid, i_req0_op_a, i_req0_op_b, i_req0_alu_op,
    input  i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_alu_op,
    input  i_rsp0_ready, i_rsp1_ready,
    output o_req0_ready, o_req1_ready,
    output o_rsp0_valid, o_rsp0_data, o_rsp0_err,
    output o_rsp1_valid, o_rsp1_data, o_rsp1_err,
    output o_busy, o_op_count
  );

  modport master (
    output i_req0_valid, i_req0_op_a, i_req0_op_b, i_req0_alu_op,
    output i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_alu_op,
    output i_rsp0_ready, i_rsp1_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp0_valid, o_rsp0_data, o_rsp0_err,
    input  o_rsp1_valid, o_rsp1_data, o_rsp1_err,
    input  o_busy, o_op_count
  );

endinterface

// File: rtl/alu.sv
// alu: purely combinational RV32I integer ALU.
//   i_op_a, i_op_b : operands
//   i_alu_op       : opcode (alu_pkg encoding)
//   o_alu_data     : result; 0 for undefined opcodes
module alu
  import alu_pkg::*;
(
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  alu_op_t     i_alu_op,
  output logic [31:0] o_alu_data
);

  logic [4:0] shamt;
  assign shamt = i_op_b[4:0];

  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    o_alu_data = '0;
    case (i_alu_op)
      OP_ADD:  o_alu_data = i_op_a + i_op_b;
      OP_SUB:  o_alu_data = i_op_a - i_op_b;
      OP_SLT:  o_alu_data = {31'd0, $signed(i_op_a) < $signed(i_op_b)};
      OP_SLTU: o_alu_data = {31'd0, i_op_a < i_op_b};
      OP_XOR:  o_alu_data = i_op_a ^ i_op_b;
      OP_OR:   o_alu_data = i_op_a | i_op_b;
      OP_AND:  o_alu_data = i_op_a & i_op_b;
      OP_SLL:  o_alu_data = i_op_a << shamt;
      OP_SRL:  o_alu_data = i_op_a >> shamt;
      OP_SRA:  o_alu_data = $unsigned($signed(i_op_a) >>> shamt);
      default: o_alu_data = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU. One operation at a time goes
// IDLE (grant + accept) -> EXEC (compute) -> RESP (hold result until taken).
//   i_clk   : clock, rising edge
//   i_reset : asynchronous, active-high reset
//   bus     : alu_arbiter_if slave (requests, responses, busy, op count)
// RR_EN = 1 alternates on contention, RR_EN = 0 always favours requester 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input logic          i_clk,
  input logic          i_reset,
  alu_arbiter_if.slave bus
);

  state_e           state_q;
  logic             grant_idx_q;
  logic             last_grant_q;
  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_err_q;
  logic [31:0]      rsp_data_q [2];
  logic [CNT_W-1:0] count_q;
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  alu_op_t          alu_op_q;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic             grant_d;
  logic             accept;
  logic [31:0]      op_a_d;
  logic [31:0]      op_b_d;
  alu_op_t          alu_op_d;
  logic [31:0]      alu_data;

  assign req_valid = {bus.i_req1_valid, bus.i_req0_valid};
  assign rsp_ready = {bus.i_rsp1_ready, bus.i_rsp0_ready};

  // Winner among the currently valid requesters.
  always_comb begin
    grant_d = 1'b0;
    if (req_valid == 2'b10) begin
      grant_d = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant_d = RR_EN ? ~last_grant_q : 1'b0;
    end
  end

  // Readies are combinational in IDLE and forced low while reset is held.
  assign accept = (state_q == ST_IDLE) && (req_valid != 2'b00) && !i_reset;

  assign bus.o_req0_ready = accept && !grant_d;
  assign bus.o_req1_ready = accept &&  grant_d;

  assign op_a_d   = grant_d ? bus.i_req1_op_a   : bus.i_req0_op_a;
  assign op_b_d   = grant_d ? bus.i_req1_op_b   : bus.i_req0_op_b;
  assign alu_op_d = grant_d ? bus.i_req1_alu_op : bus.i_req0_alu_op;

  alu u_alu (
    .i_op_a     (op_a_q),
    .i_op_b     (op_b_q),
    .i_alu_op   (alu_op_q),
    .o_alu_data (alu_data)
  );

  // NOTE: operand registers carry no reset; they are always loaded on accept before EXEC reads them.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= 1'b0;
      last_grant_q  <= 1'b1;  // requester 0 wins the first contention
      rsp_valid_q   <= '0;
      rsp_err_q     <= '0;
      rsp_data_q[0] <= '0;
      rsp_data_q[1] <= '0;
      count_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            grant_idx_q  <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Only the granted response lane is written; the other holds.
          rsp_data_q[grant_idx_q]  <= alu_data;
          rsp_err_q[grant_idx_q]   <= !is_legal_op(alu_op_q);
          rsp_valid_q[grant_idx_q] <= 1'b1;
          state_q                  <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[grant_idx_q]) begin
            rsp_valid_q[grant_idx_q] <= 1'b0;
            count_q                  <= count_q + CNT_W'(1);
            state_q                  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_rsp0_valid = rsp_valid_q[0];
  assign bus.o_rsp1_valid = rsp_valid_q[1];
  assign bus.o_rsp0_data  = rsp_data_q[0];
  assign bus.o_rsp1_data  = rsp_data_q[1];
  assign bus.o_rsp0_err   = rsp_err_q[0];
  assign bus.o_rsp1_err   = rsp_err_q[1];
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_op_count   = count_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin grant, 0 = fixed priority with requester 0 winning.
REQ-002 Parameter CNT_W, default 16, meaning: width of the completed-operation counter.
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_req0_valid / i_req1_valid  input  1  the requester presents an operation.
REQ-006 o_req0_ready / o_req1_ready  output  1  the block accepts the operation this cycle.
REQ-007 i_req0_op_a, i_req0_op_b / i_req1_op_a, i_req1_op_b  input  32 each  operands.
REQ-008 i_req0_alu_op / i_req1_alu_op  input  4  ALU opcode, encoded per the shared package.
REQ-009 o_rsp0_valid / o_rsp1_valid  output  1  result available for that requester.
REQ-010 i_rsp0_ready / i_rsp1_ready  input  1  the requester consumes the result.
REQ-011 o_rsp0_data / o_rsp1_data  output  32  ALU result.
REQ-012 o_rsp0_err / o_rsp1_err  output  1  the opcode was not defined.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.
REQ-014 o_op_count  output  CNT_W  number of responses consumed, wrapping.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 In IDLE, the block SHALL assert the ready of the granted valid requester combinationally; all other readies SHALL stay 0; readies SHALL be 0 in EXEC and RESP.
REQ-017 Grant: a single valid requester SHALL win; with both valid and RR_EN=1, the requester not granted last SHALL win; with RR_EN=0, requester 0 SHALL win.
REQ-018 On the handshake edge (valid & ready), the block SHALL register op_a, op_b, alu_op and the grant index, update last_grant, and go to EXEC.
REQ-019 In EXEC, the registered operands SHALL drive the single ALU instance; at the next edge, the result SHALL be registered into the granted rsp data and the state SHALL go to RESP.
REQ-020 In RESP, only the granted o_rspN_valid SHALL be 1, with data and err held stable until i_rspN_ready is sampled high.
REQ-021 On that edge, valid SHALL drop, o_op_count SHALL increment (modulo 2^CNT_W) and the state SHALL return to IDLE.
REQ-022 Latency: the response valid SHALL be high from 2 edges after the handshake; the minimum issue interval SHALL be 3 cycles.
REQ-023 Opcodes ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL and SRA (0-9) SHALL give the RV32I result, with shifts using op_b[4:0] and SLT/SLTU returning 0 or 1.
REQ-024 Opcodes 10-15 SHALL give data 0 and err 1, while still following the full handshake and incrementing the count.
REQ-025 Requesters SHALL hold valid and payload until ready; a valid dropped before the handshake SHALL leave no side effect.
REQ-026 A request arriving while busy SHALL wait and SHALL NOT be lost or reordered.
REQ-027 An unconsumed response SHALL block all new grants (no overwrite).
REQ-028 An unused rsp data output SHALL hold its last value, and its err SHALL be held likewise.

Reset
REQ-029 i_reset high SHALL immediately (asynchronously) force: state IDLE, all rsp valid 0, all rsp data 0, all err 0, o_busy 0, o_op_count 0, and last_grant = 1 so that requester 0 wins first.
REQ-030 Reset during EXEC or RESP SHALL discard the in-flight operation, with no response ever issued for it.
REQ-031 Ready outputs SHALL be 0 while reset is asserted.

Structure
REQ-032 Package alu_pkg SHALL hold the 4-bit opcode constants (ADD=0 … SRA=9), the opcode typedef and the FSM state enum.
REQ-033 The datapath SHALL be one instance of the sub-module alu (ports i_op_a, i_op_b, i_alu_op, o_alu_data); all sequencing SHALL reside in alu_arbiter.

Verification
REQ-034 Single request: req0 ADD with a=3232453, b=4995 -> rsp0 valid 2 edges after accept, data 3237448, err 0, count 1.
REQ-035 Contention after reset: both valid, with req0 SUB a=43750349, b=-392837334 and req1 XOR a=12398, b=45 -> rsp0 436587683 first; then req1 is granted the cycle after rsp0 is consumed and returns 12355.
REQ-036 Round-robin: both requesters are held valid for 4 operations -> grant order 0, 1, 0, 1; with RR_EN=0 the order is 0, 0, 0, 0.
REQ-037 Backpressure: i_rsp0_ready held low for 5 cycles -> data stable, o_busy 1, o_req1_ready 0 throughout.
REQ-038 Illegal opcode: req1 op 4'b1111 -> rsp1 data 0, err 1; SLT a=-5, b=3 -> 1; SLTU a=-5, b=3 -> 0.
REQ-039 Reset asserted in EXEC -> outputs are at reset values within the same cycle, no rsp valid appears afterwards, and count is 0.
